// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one fixed-latency ALU between two requesters. One operation is
//   accepted at a time over a valid/ready handshake, with round-robin
//   arbitration when both requesters are valid. The accepted operands are
//   driven to the ALU and held. The arbiter waits LAT clock edges, captures
//   ALUOut and the flags, and returns them with the requester id over a
//   valid/ready response channel. At most one operation is outstanding.
//
// Parameters:
//   LAT : edges from operand load to result/flag sample (ALU output is
//         registered at +1 and its flags at +3, so LAT must be >= 4)
//   DW  : operand/result width
//
// Ports:
//   clock        in   system clock, all state on the rising edge
//   reset_n      in   asynchronous active-low reset
//   req0_valid   in   requester 0 has an operation
//   req0_ready   out  requester 0 operation accepted this cycle
//   req0_funsel  in   requester 0 ALU function select
//   req0_a/b     in   requester 0 operands
//   req0_cin     in   requester 0 carry-in
//   req1_*            same set for requester 1
//   rsp_valid    out  response available
//   rsp_ready    in   consumer takes the response
//   rsp_id       out  requester index of the response
//   rsp_data     out  captured ALUOut
//   rsp_flags    out  captured flags {Z,C,N,V}
//   alu_a/b      out  to ALU input_a/input_b
//   alu_funsel   out  to ALU FunSel
//   alu_cin      out  to ALU cin
//   alu_out      in   from ALU ALUOut
//   alu_flags    in   from ALU flags {Z,C,N,V}
//   busy         out  high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned LAT = 4,
   parameter int unsigned DW  = 32
) (
   input  logic          clock,
   input  logic          reset_n,

   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [4:0]    req0_funsel,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req0_cin,

   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [4:0]    req1_funsel,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic          req1_cin,

   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_data,
   output logic [3:0]    rsp_flags,

   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [4:0]    alu_funsel,
   output logic          alu_cin,
   input  logic [DW-1:0] alu_out,
   input  logic [3:0]    alu_flags,

   output logic          busy
);

   localparam int unsigned CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic          last_grant;
   logic          cur_id;
   logic [CW-1:0] wait_cnt;

   logic          grant_any;
   logic          grant_id;

   // Round-robin: on contention the requester that did not win last time is
   // chosen; a lone requester always wins regardless of history.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = req1_valid;
      end
   end

   // Readies are gated by reset_n so nothing appears accepted while the
   // block is held in reset.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (reset_n && (state == IDLE) && grant_any) begin
         req0_ready = ~grant_id;
         req1_ready =  grant_id;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         wait_cnt   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_flags  <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_funsel <= '0;
         alu_cin    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  if (grant_id) begin
                     alu_a      <= req1_a;
                     alu_b      <= req1_b;
                     alu_funsel <= req1_funsel;
                     alu_cin    <= req1_cin;
                  end else begin
                     alu_a      <= req0_a;
                     alu_b      <= req0_b;
                     alu_funsel <= req0_funsel;
                     alu_cin    <= req0_cin;
                  end
                  cur_id     <= grant_id;
                  last_grant <= grant_id;
                  wait_cnt   <= CW'(LAT);
                  state      <= EXEC;
               end
            end

            // alu_* are deliberately not touched here: the ALU's flag
            // terms are computed from operands that must stay put until
            // the flags are sampled.
            EXEC: begin
               wait_cnt <= wait_cnt - CW'(1);
               if (wait_cnt == CW'(1)) begin
                  rsp_data  <= alu_out;
                  rsp_flags <= alu_flags;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end

            // Returning to IDLE costs one edge; the next accept can only
            // happen on the edge after that.
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small behavioural ALU stands in for the
// real one: its result appears one edge after the operands change and its
// flags three edges after, so a wrong sample point yields stale data.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int LAT = 4;
   localparam int DW  = 32;

   logic          clock;
   logic          reset_n;

   logic          req0_valid;
   logic          req0_ready;
   logic [4:0]    req0_funsel;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic          req0_cin;

   logic          req1_valid;
   logic          req1_ready;
   logic [4:0]    req1_funsel;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic          req1_cin;

   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [DW-1:0] rsp_data;
   logic [3:0]    rsp_flags;

   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [4:0]    alu_funsel;
   logic          alu_cin;
   logic [DW-1:0] alu_out   = '0;
   logic [3:0]    alu_flags = '0;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   alu_arbiter #(.LAT(LAT), .DW(DW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_funsel (req0_funsel),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_cin    (req0_cin),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_funsel (req1_funsel),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_cin    (req1_cin),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_flags   (rsp_flags),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_funsel  (alu_funsel),
      .alu_cin     (alu_cin),
      .alu_out     (alu_out),
      .alu_flags   (alu_flags),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural ALU: 10100 add, 10101 add+cin, 10110 sub (C = no borrow),
   // 11011 shift left (C = bit shifted out), anything else AND.
   function automatic logic [35:0] alu_calc(input logic [4:0] fs,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic cin);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      logic        v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (fs)
         5'b10100: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b10101: begin
            s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b10110: begin
            r = a - b; c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         5'b11011: begin
            r = a << 1; c = a[31];
         end
         default: r = a & b;
      endcase
      return {(r == 32'd0), c, r[31], v, r};
   endfunction

   logic [35:0] alu_calc_now;
   logic [3:0]  flag_p1 = '0;
   logic [3:0]  flag_p2 = '0;
   assign alu_calc_now = alu_calc(alu_funsel, alu_a, alu_b, alu_cin);

   always @(posedge clock) begin
      alu_out   <= alu_calc_now[31:0];
      flag_p1   <= alu_calc_now[35:32];
      flag_p2   <= flag_p1;
      alu_flags <= flag_p2;
   end

   // Bounded wait for rsp_valid; n = edges taken, -1 when the budget runs out.
   task automatic wait_rsp(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         n++;
         if (rsp_valid) return;
      end
      n = -1;
   endtask

   // Bounded wait for a ready; who = 0/1, 2 if both, -1 on timeout.
   task automatic wait_ready(output int who);
      who = -1;
      for (int i = 0; i < 20; i++) begin
         if (req0_ready && req1_ready) begin who = 2; return; end
         if (req0_ready) begin who = 0; return; end
         if (req1_ready) begin who = 1; return; end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset;
      reset_n    = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         fails++;
         $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      tests++;
      if ({rsp_valid, rsp_id, busy, alu_cin} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 0000", {rsp_valid, rsp_id, busy, alu_cin});
      end
      tests++;
      if ({rsp_data, rsp_flags, alu_a, alu_b, alu_funsel} !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all 0",
                  rsp_data, rsp_flags, alu_a, alu_b, alu_funsel);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset_n    = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_single;
      int n;
      rsp_ready   = 1'b0;
      req0_valid  = 1'b1;
      req0_funsel = 5'b10100;
      req0_a      = 32'h0000_0005;
      req0_b      = 32'h0000_0003;
      req0_cin    = 1'b0;
      #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      tests++;
      if ({req0_ready, busy} !== 2'b01) begin
         fails++;
         $display("FAIL single_exec: ready/busy got %b expected 01", {req0_ready, busy});
      end
      tests++;
      if ({alu_a, alu_b, alu_funsel, alu_cin} !== {32'h5, 32'h3, 5'b10100, 1'b0}) begin
         fails++;
         $display("FAIL single_alu_in: got %h %h %b %b expected 5 3 10100 0",
                  alu_a, alu_b, alu_funsel, alu_cin);
      end
      wait_rsp(n);
      tests++;
      if (n !== LAT) begin
         fails++;
         $display("FAIL single_latency: got %0d edges expected %0d", n, LAT);
      end
      tests++;
      if ({rsp_id, rsp_flags, rsp_data} !== {1'b0, 4'b0000, 32'h8}) begin
         fails++;
         $display("FAIL single_rsp: got id=%b flags=%b data=%h expected id=0 flags=0000 data=8",
                  rsp_id, rsp_flags, rsp_data);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      tests++;
      if ({rsp_valid, busy} !== 2'b00) begin
         fails++;
         $display("FAIL single_done: valid/busy got %b expected 00", {rsp_valid, busy});
      end
   endtask

   task automatic test_contention;
      int who;
      int n;
      int n0;
      int n1;
      int e;
      int j;
      logic [31:0] exp_data;
      logic [3:0]  exp_flags;
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n     = 1'b1;
      rsp_ready   = 1'b1;
      n0 = 0;
      n1 = 0;
      req0_valid  = 1'b1; req0_funsel = 5'b10100; req0_a = 32'h1;    req0_b = 32'h100; req0_cin = 1'b0;
      req1_valid  = 1'b1; req1_funsel = 5'b10110; req1_a = 32'h1000; req1_b = 32'h5;   req1_cin = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         e = k % 2;
         j = k / 2;
         wait_ready(who);
         tests++;
         if (who !== e) begin
            fails++;
            $display("FAIL contention_grant%0d: got %0d expected %0d", k, who, e);
            break;
         end
         @(posedge clock); #1;
         if (who == 0) begin
            n0++;
            if (n0 == 3) req0_valid = 1'b0;
            else req0_a = 32'(n0 + 1);
         end else begin
            n1++;
            if (n1 == 3) req1_valid = 1'b0;
            else req1_a = 32'h1000 + 32'(n1);
         end
         exp_data  = (e == 0) ? 32'h101 + 32'(j) : 32'hFFB + 32'(j);
         exp_flags = (e == 0) ? 4'b0000 : 4'b0100;
         wait_rsp(n);
         tests++;
         if ({rsp_id, rsp_flags, rsp_data} !== {e[0], exp_flags, exp_data} || n != LAT) begin
            fails++;
            $display("FAIL contention_rsp%0d: got id=%b flags=%b data=%h n=%0d expected id=%0d flags=%b data=%h n=%0d",
                     k, rsp_id, rsp_flags, rsp_data, n, e, exp_flags, exp_data, LAT);
         end
         @(posedge clock); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      int n;
      rsp_ready   = 1'b0;
      req1_valid  = 1'b1;
      req1_funsel = 5'b10100;
      req1_a      = 32'hFFFF_FFFF;
      req1_b      = 32'h0000_0001;
      req1_cin    = 1'b0;
      #1;
      @(posedge clock); #1;
      req1_valid  = 1'b0;
      req0_valid  = 1'b1;
      req0_funsel = 5'b10100;
      req0_a      = 32'h11;
      req0_b      = 32'h22;
      wait_rsp(n);
      tests++;
      if (n !== LAT) begin
         fails++;
         $display("FAIL bp_latency: got %0d expected %0d", n, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         tests++;
         if ({rsp_valid, rsp_id, rsp_flags, busy, req0_ready, req1_ready, rsp_data}
             !== {1'b1, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL bp_hold%0d: got v=%b id=%b flags=%b busy=%b rdy=%b%b data=%h expected v=1 id=1 flags=1100 busy=1 rdy=00 data=0",
                     i, rsp_valid, rsp_id, rsp_flags, busy, req0_ready, req1_ready, rsp_data);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      tests++;
      if ({rsp_valid, busy, req0_ready} !== 3'b001) begin
         fails++;
         $display("FAIL bp_release: valid/busy/req0_ready got %b expected 001",
                  {rsp_valid, busy, req0_ready});
      end
      req0_valid = 1'b0;
      @(posedge clock); #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_withdraw: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_flags;
      int n;
      rsp_ready   = 1'b1;
      req1_valid  = 1'b1;
      req1_funsel = 5'b10110;
      req1_a      = 32'h1234_5678;
      req1_b      = 32'h1234_5678;
      #1;
      tests++;
      if (req1_ready !== 1'b1) begin
         fails++;
         $display("FAIL flags_ready: got %b expected 1", req1_ready);
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      wait_rsp(n);
      tests++;
      if ({rsp_data, rsp_flags[3]} !== {32'h0, 1'b1} || rsp_flags !== 4'b1100) begin
         fails++;
         $display("FAIL flags_zero: got data=%h flags=%b expected data=0 flags=1100", rsp_data, rsp_flags);
      end
      @(posedge clock); #1;
      req1_valid  = 1'b1;
      req1_funsel = 5'b11011;
      req1_a      = 32'h8000_0000;
      req1_b      = 32'h0;
      #1;
      @(posedge clock); #1;
      req1_valid = 1'b0;
      wait_rsp(n);
      tests++;
      if ({rsp_data, rsp_flags[2]} !== {32'h0, 1'b1} || rsp_flags !== 4'b1100) begin
         fails++;
         $display("FAIL flags_carry: got data=%h flags=%b expected data=0 flags=1100", rsp_data, rsp_flags);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_operand_stability;
      int n;
      rsp_ready   = 1'b1;
      req0_valid  = 1'b1;
      req0_funsel = 5'b10100;
      req0_a      = 32'h10;
      req0_b      = 32'h20;
      req0_cin    = 1'b0;
      #1;
      @(posedge clock); #1;
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         req0_a = $urandom;
         req0_b = $urandom;
         @(posedge clock); #1;
         if (rsp_valid) begin n = i; break; end
         tests++;
         if ({alu_a, alu_b} !== {32'h10, 32'h20}) begin
            fails++;
            $display("FAIL stab_hold%0d: got a=%h b=%h expected a=10 b=20", i, alu_a, alu_b);
         end
      end
      req0_valid = 1'b0;
      tests++;
      if (rsp_data !== 32'h30 || n != LAT) begin
         fails++;
         $display("FAIL stab_result: got data=%h n=%0d expected data=30 n=%0d", rsp_data, n, LAT);
      end
      @(posedge clock); #1;
      tests++;
      if ({busy, alu_a, alu_b} !== {1'b0, 32'h10, 32'h20}) begin
         fails++;
         $display("FAIL stab_idle_keep: got busy=%b a=%h b=%h expected busy=0 a=10 b=20",
                  busy, alu_a, alu_b);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      logic seen;
      rsp_ready   = 1'b1;
      req0_valid  = 1'b1;
      req0_funsel = 5'b10100;
      req0_a      = 32'h7;
      req0_b      = 32'h9;
      #1;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      @(posedge clock);
      @(posedge clock); #1;
      reset_n    = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req1_funsel = 5'b10100;
      req1_a     = 32'h100;
      req1_b     = 32'h1;
      #1;
      tests++;
      if ({rsp_valid, rsp_id, busy, alu_cin, req0_ready, req1_ready} !== 6'b0) begin
         fails++;
         $display("FAIL midrst_ctrl: got %b expected 000000",
                  {rsp_valid, rsp_id, busy, alu_cin, req0_ready, req1_ready});
      end
      tests++;
      if ({rsp_data, rsp_flags, alu_a, alu_b, alu_funsel} !== '0) begin
         fails++;
         $display("FAIL midrst_data: got %h/%h/%h/%h/%h expected all 0",
                  rsp_data, rsp_flags, alu_a, alu_b, alu_funsel);
      end
      seen = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
         if (rsp_valid) seen = 1'b1;
      end
      reset_n = 1'b1;
      #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL midrst_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == LAT - 1) break;
         @(posedge clock); #1;
         if (rsp_valid) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL midrst_no_rsp: rsp_valid got 1 early expected 0");
      end
      wait_rsp(n);
      tests++;
      if ({rsp_id, rsp_data} !== {1'b0, 32'h10} || n != 1) begin
         fails++;
         $display("FAIL midrst_after: got id=%b data=%h n=%0d expected id=0 data=10 n=1",
                  rsp_id, rsp_data, n);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_back_to_back;
      int who;
      int n;
      int prev_acc;
      int acc;
      rsp_ready   = 1'b1;
      req0_valid  = 1'b1;
      req0_funsel = 5'b10101;
      req0_a      = 32'h0;
      req0_b      = 32'h1;
      req0_cin    = 1'b1;
      #1;
      prev_acc = -1;
      for (int k = 0; k < 3; k++) begin
         wait_ready(who);
         acc = cyc + 1;
         tests++;
         if (who !== 0) begin
            fails++;
            $display("FAIL b2b_grant%0d: got %0d expected 0", k, who);
            break;
         end
         if (prev_acc >= 0) begin
            tests++;
            if (acc - prev_acc !== LAT + 2) begin
               fails++;
               $display("FAIL b2b_interval%0d: got %0d cycles expected %0d", k, acc - prev_acc, LAT + 2);
            end
         end
         prev_acc = acc;
         @(posedge clock); #1;
         if (k == 2) req0_valid = 1'b0;
         else req0_a = 32'(k + 1);
         wait_rsp(n);
         tests++;
         if ({rsp_id, rsp_flags, rsp_data} !== {1'b0, 4'b0000, 32'(k + 2)} || n != LAT) begin
            fails++;
            $display("FAIL b2b_rsp%0d: got id=%b flags=%b data=%h n=%0d expected id=0 flags=0000 data=%h n=%0d",
                     k, rsp_id, rsp_flags, rsp_data, n, 32'(k + 2), LAT);
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      req0_valid  = 1'b0; req0_funsel = '0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid  = 1'b0; req1_funsel = '0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      rsp_ready   = 1'b0;
      @(posedge clock); #1;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_flags();
      test_operand_stability();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, expected to finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters (e.g. fetch/address unit and execute unit).
- Accepts one operation at a time over a valid/ready handshake, using round-robin arbitration.
- Drives the ALU operand, FunSel and cin inputs, waits the ALU's fixed result/flag latency, then returns ALUOut and flags with the requester id over a valid/ready response channel.
- Single outstanding operation.

Parameters:
- LAT, 4, clock edges after operand load at which ALUOut and flags (Z|C|N|V) are sampled. The ALU registers its output at +1 and its flags at +3, so the minimum legal value is 4.
- DW, 32, operand/result width.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_funsel  input  5  ALU function select
- req0_a  input  DW  operand A
- req0_b  input  DW  operand B
- req0_cin  input  1  carry-in
- req1_valid, req1_ready, req1_funsel, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester index of response
- rsp_data  output  DW  captured ALUOut
- rsp_flags  output  4  captured flags {Z,C,N,V}
- alu_a  output  DW  to ALU input_a
- alu_b  output  DW  to ALU input_b
- alu_funsel  output  5  to ALU FunSel
- alu_cin  output  1  to ALU cin
- alu_out  input  DW  from ALU ALUOut
- alu_flags  input  4  from ALU flags
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clock); reset_n is asynchronous, active-low.
- Reset state: IDLE, last_grant=1. All of the following are 0: rsp_valid, rsp_id, rsp_data, rsp_flags, alu_a, alu_b, alu_funsel, alu_cin, busy, wait counter.
- While reset_n=0, req0_ready and req1_ready are 0.
- States are IDLE, EXEC and RESP.
- IDLE arbitration (combinational):
  - One valid requester: it is granted.
  - Both valid: grant the requester != last_grant.
  - req_ready of the granted requester is 1 only in IDLE; the other ready is 0.
- Accept edge (IDLE with a granted valid):
  - Load alu_a, alu_b, alu_funsel and alu_cin from the granted requester.
  - Record id, set last_grant=id, set counter=LAT, go to EXEC.
- EXEC:
  - alu_* registers are held constant for the whole of EXEC; the ALU's carry/overflow terms depend on operands being stable after the output edge.
  - Counter decrements each edge.
  - On the edge where the counter is 1: capture alu_out into rsp_data and alu_flags into rsp_flags, set rsp_id=id, set rsp_valid=1, go to RESP.
  - Accept-to-rsp_valid latency is exactly LAT edges.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: clear rsp_valid and go to IDLE.
  - No new accept happens in the same edge; the earliest next accept is the following edge. Back-to-back throughput is therefore 1 op per LAT+2 cycles.
- alu_* outputs keep their last values in IDLE and RESP; they do not return to 0.
- Requester inputs are sampled only on the accept edge. Changes afterwards have no effect.
- A requester that drops valid before being granted is simply not granted; no error is raised.
- last_grant updates only on accept. If a single requester issues repeatedly, it keeps winning while the other is idle.
- Reset mid-operation: the in-flight op is discarded with no response, and all state returns to reset values immediately.
- No width conversion: rsp_data = alu_out bit-exact, including the ALU's 16-bit sign-extended modes.

Test Plan:
- Single op: req0 valid, funsel=5'b10100, a=32'h0000_0005, b=32'h0000_0003. Expected: req0_ready=1 for exactly one cycle; rsp_valid rises 4 edges later with rsp_data=32'h8, rsp_flags=4'b0000, rsp_id=0.
- Contention: req0 and req1 both valid from reset, each issuing 3 ops with rsp_ready=1. Expected grant order 0,1,0,1,0,1; each response has the matching id and data.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid. Expected: rsp_data/rsp_flags/rsp_id stable, busy=1, both readies 0; IDLE is reached one edge after rsp_ready=1.
- Flag capture: req1 funsel=5'b10110, a=b=32'h1234_5678. Expected: rsp_data=0 and rsp_flags Z bit=1. Then funsel=5'b11011, a=32'h8000_0000 gives rsp_data=0 and C=1.
- Operand stability: change req0_a/req0_b every cycle after accept. Expected: alu_a/alu_b remain at the accepted values until RESP; the result matches the accepted operands.
- Reset mid-EXEC: assert reset_n=0 two edges after accept. Expected: rsp_valid never rises, all outputs are 0, and after release req0 is granted first when both are valid.
